// File: rtl/dmem_pkg.sv
// Shared types and default widths for the wait-state data memory.
// Holds the controller state encoding and the default word/address widths.
package dmem_pkg;

   localparam int DMEM_DW = 48;
   localparam int DMEM_AW = 15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM, DW x DEPTH, registered read, no reset.
// Ports: clk, we_i/re_i enables, addr_i word index, wdata_i, rdata_o.
module dmem_array #(
   parameter int DW    = 48,
   parameter int DEPTH = 32768,
   parameter int IW    = 15
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [IW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmemory_wait.sv
// Data memory with a configurable number of wait states per access.
// Ports: clk, reset_n (sync, active low); request i_addr/i_read/i_write/
// i_data; response o_data/o_done/o_err, o_busy while in wait states.
module dmemory_wait
   import dmem_pkg::*;
#(
   parameter int DW    = DMEM_DW,
   parameter int AW    = DMEM_AW,
   parameter int DEPTH = 32768,
   parameter int WAIT  = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] i_addr,
   input  logic          i_read,
   input  logic          i_write,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_done,
   output logic          o_busy,
   output logic          o_err
);

   localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] WAIT_C  = CW'(WAIT);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          we_q;
   logic          err_q, err_d;
   logic          zero_q, zero_d;

   logic          req_ok, req_bad, accept, fire, in_range;
   logic [AW-1:0] acc_addr;
   logic          acc_we;
   logic [DW-1:0] acc_data;
   logic          ram_we, ram_re;
   logic [DW-1:0] ram_rdata;

   assign req_ok  = i_read ^ i_write;
   assign req_bad = i_read & i_write;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      zero_d   = zero_q;
      accept   = 1'b0;
      fire     = 1'b0;
      acc_addr = addr_q;
      acc_we   = we_q;
      acc_data = data_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (req_ok) begin
               accept = 1'b1;
               // Zero wait: access straight from the request inputs.
               if (WAIT == 0) begin
                  fire     = 1'b1;
                  acc_addr = i_addr;
                  acc_we   = i_write;
                  acc_data = i_data;
                  state_d  = S_DONE;
               end else begin
                  cnt_d   = WAIT_C;
                  state_d = S_WAIT;
               end
            end else if (req_bad) begin
               err_d = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
               fire    = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_range = ({1'b0, acc_addr} < DEPTH_C);
      if (fire) begin
         if (!in_range) err_d = 1'b1;
         // Out-of-range reads present zero until the next read lands.
         if (!acc_we) zero_d = !in_range;
      end
   end

   // Gating on reset_n abandons an access whose final edge sees reset.
   assign ram_we = fire & acc_we & in_range & reset_n;
   assign ram_re = fire & ~acc_we & in_range & reset_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && accept) begin
         addr_q <= i_addr;
         data_q <= i_data;
         we_q   <= i_write;
      end
   end

   dmem_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (acc_addr[IW-1:0]),
      .wdata_i (acc_data),
      .rdata_o (ram_rdata)
   );

   assign o_data = zero_q ? '0 : ram_rdata;
   assign o_done = (state_q == S_DONE);
   assign o_busy = (state_q == S_WAIT);
   assign o_err  = err_q;

endmodule

// File: tb/tb_dmemory_wait.sv
// Scoreboard bench: two instances (0 and 3 wait states, 1000 words).
// Requests push expected responses; a negedge monitor pops and compares.
module tb_dmemory_wait;

   logic        clk = 1'b0;
   logic        rn [2];
   logic        rd [2];
   logic        wr [2];
   logic [14:0] ad [2];
   logic [47:0] wd [2];
   logic [47:0] od [2];
   logic        dn [2];
   logic        bz [2];
   logic        er [2];

   always #5 clk = ~clk;

   dmemory_wait #(.DW(48), .AW(15), .DEPTH(1000), .WAIT(0)) u0 (
      .clk(clk), .reset_n(rn[0]), .i_addr(ad[0]), .i_read(rd[0]),
      .i_write(wr[0]), .i_data(wd[0]), .o_data(od[0]),
      .o_done(dn[0]), .o_busy(bz[0]), .o_err(er[0])
   );

   dmemory_wait #(.DW(48), .AW(15), .DEPTH(1000), .WAIT(3)) u1 (
      .clk(clk), .reset_n(rn[1]), .i_addr(ad[1]), .i_read(rd[1]),
      .i_write(wr[1]), .i_data(wd[1]), .o_data(od[1]),
      .o_done(dn[1]), .o_busy(bz[1]), .o_err(er[1])
   );

   typedef struct {
      int          due;
      bit          done;
      bit          err;
      bit          chk;
      logic [47:0] data;
      bit          undo;
      int          key;
      bit          had;
      logic [47:0] old;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [47:0] mem [int];
   int          cyc = 0;
   int          checks = 0;
   int          errs = 0;
   int          bf [2];
   int          bt [2];
   logic [47:0] ld [2];
   bit          lk [2];
   bit          en [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int qsize(int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void qpush(int d, exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic exp_t qfront(int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   function automatic exp_t qback(int d);
      return (d == 0) ? q0[$] : q1[$];
   endfunction

   function automatic void qpopf(int d);
      if (d == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endfunction

   function automatic void qpopb(int d);
      if (d == 0) void'(q0.pop_back());
      else void'(q1.pop_back());
   endfunction

   task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic mon(int d);
      exp_t e;
      logic ebz;
      if (qsize(d) > 0) begin
         e = qfront(d);
         if (e.due < cyc) begin
            checks++;
            errs++;
            $display("FAIL d%0d timeout: no response due at cycle %0d",
                     d, e.due);
            qpopf(d);
         end
      end
      ebz = (cyc >= bf[d]) && (cyc <= bt[d]);
      checks++;
      if (bz[d] !== ebz) begin
         errs++;
         $display("FAIL d%0d busy @%0d: got %b want %b",
                  d, cyc, bz[d], ebz);
      end
      if (dn[d] === 1'b1 || er[d] === 1'b1) begin
         checks++;
         if (qsize(d) == 0) begin
            errs++;
            $display("FAIL d%0d unexpected @%0d: done=%b err=%b",
                     d, cyc, dn[d], er[d]);
         end else begin
            e = qfront(d);
            qpopf(d);
            if (cyc != e.due || dn[d] !== e.done || er[d] !== e.err ||
                (e.chk && od[d] !== e.data)) begin
               errs++;
               $display({"FAIL d%0d resp: got cyc=%0d done=%b err=%b ",
                         "data=%h want cyc=%0d done=%b err=%b data=%h"},
                        d, cyc, dn[d], er[d], od[d],
                        e.due, e.done, e.err, e.data);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) if (en[d]) mon(d);
   end

   task automatic issue(int d, bit r, bit w, logic [14:0] a,
                        logic [47:0] v);
      int   c, wt, k;
      bit   inr;
      exp_t e;
      c  = cyc;
      wt = (d == 0) ? 0 : 3;
      rd[d] = r;
      wr[d] = w;
      ad[d] = a;
      wd[d] = v;
      if (rn[d] && c > bt[d] && (r || w)) begin
         e.due  = c + 1;
         e.done = 1'b0;
         e.err  = 1'b1;
         e.chk  = lk[d];
         e.data = ld[d];
         e.undo = 1'b0;
         e.key  = 0;
         e.had  = 1'b0;
         e.old  = '0;
         if (!(r && w)) begin
            inr    = (a < 1000);
            e.due  = c + wt + 1;
            e.done = 1'b1;
            e.err  = !inr;
            if (wt > 0) begin
               bf[d] = c + 1;
               bt[d] = c + wt;
            end
            k = d * 100000 + int'(a);
            if (w) begin
               if (inr) begin
                  e.undo = 1'b1;
                  e.key  = k;
                  e.had  = mem.exists(k);
                  if (e.had) e.old = mem[k];
                  mem[k] = v;
               end
            end else begin
               if (!inr) begin
                  ld[d] = '0;
                  lk[d] = 1'b1;
               end else if (mem.exists(k)) begin
                  ld[d] = mem[k];
                  lk[d] = 1'b1;
               end else begin
                  lk[d] = 1'b0;
               end
               e.chk  = lk[d];
               e.data = ld[d];
            end
         end
         qpush(d, e);
      end
      @(posedge clk); #1;
      rd[d] = 1'b0;
      wr[d] = 1'b0;
   endtask

   task automatic nop(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(int d);
      int lim;
      lim = 0;
      while (cyc <= bt[d] && lim < 20) begin
         @(posedge clk); #1;
         lim++;
      end
   endtask

   task automatic do_reset(int d, int n);
      int   r;
      exp_t e;
      r = cyc;
      rn[d] = 1'b0;
      rd[d] = 1'b0;
      wr[d] = 1'b1;
      ad[d] = '0;
      wd[d] = '1;
      repeat (n) @(posedge clk);
      #1;
      while (qsize(d) > 0 && qback(d).due > r) begin
         e = qback(d);
         if (e.undo) begin
            if (e.had) mem[e.key] = e.old;
            else mem.delete(e.key);
         end
         qpopb(d);
      end
      bf[d] = 0;
      bt[d] = -1;
      ld[d] = '0;
      lk[d] = 1'b1;
      @(negedge clk);
      chk($sformatf("d%0d rst done", d), 48'(dn[d]), 48'd0);
      chk($sformatf("d%0d rst err", d), 48'(er[d]), 48'd0);
      chk($sformatf("d%0d rst busy", d), 48'(bz[d]), 48'd0);
      chk($sformatf("d%0d rst data", d), od[d], 48'd0);
      en[d] = 1'b1;
      @(posedge clk); #1;
      rn[d] = 1'b1;
      wr[d] = 1'b0;
      wd[d] = '0;
   endtask

   task automatic run_dut(int d);
      int          op, sel;
      logic [14:0] a;
      logic [47:0] v;
      do_reset(d, 3);
      issue(d, 0, 1, 15'd0, 48'hDEAD_BEEF_0001);
      wait_idle(d);
      nop(1);
      do_reset(d, 2);
      issue(d, 1, 0, 15'd0, '0);
      wait_idle(d);
      issue(d, 0, 1, 15'd5, 48'h1234_5678_9ABC);
      wait_idle(d);
      issue(d, 1, 0, 15'd5, '0);
      wait_idle(d);
      if (d == 1) begin
         issue(d, 1, 0, 15'd5, '0);
         nop(1);
         issue(d, 1, 0, 15'd6, '0);
         wait_idle(d);
      end
      issue(d, 0, 1, 15'd7, 48'h777);
      wait_idle(d);
      issue(d, 1, 1, 15'd7, 48'hBAD);
      wait_idle(d);
      issue(d, 1, 0, 15'd7, '0);
      wait_idle(d);
      issue(d, 0, 1, 15'd1000, 48'hFFFF);
      wait_idle(d);
      issue(d, 1, 0, 15'd1000, '0);
      wait_idle(d);
      if (d == 1) begin
         issue(d, 0, 1, 15'd9, 48'h1111);
         wait_idle(d);
         issue(d, 0, 1, 15'd9, 48'hAAAA);
         nop(1);
         do_reset(d, 1);
         issue(d, 1, 0, 15'd9, '0);
         wait_idle(d);
      end
      for (int i = 0; i < 250; i++) begin
         op  = $urandom_range(0, 9);
         sel = $urandom_range(0, 7);
         if (sel < 5) a = 15'($urandom_range(0, 15));
         else if (sel == 5) a = 15'($urandom_range(996, 1003));
         else if (sel == 6) a = 15'($urandom_range(0, 999));
         else a = 15'($urandom_range(0, 32767));
         v = {16'($urandom), 32'($urandom)};
         if ($urandom_range(0, 3) != 0) wait_idle(d);
         if (op < 4) issue(d, 0, 1, a, v);
         else if (op < 8) issue(d, 1, 0, a, v);
         else if (op == 8) issue(d, 1, 1, a, v);
         else nop(1);
      end
      wait_idle(d);
      nop(6);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rn[d] = 1'b0;
         rd[d] = 1'b0;
         wr[d] = 1'b0;
         ad[d] = '0;
         wd[d] = '0;
         bf[d] = 0;
         bt[d] = -1;
         ld[d] = '0;
         lk[d] = 1'b1;
         en[d] = 1'b0;
      end
      @(posedge clk); #1;
      run_dut(0);
      run_dut(1);
      nop(10);
      chk("q0 drained", 48'(q0.size()), 48'd0);
      chk("q1 drained", 48'(q1.size()), 48'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/dmemory_wait.md
DMEMORY_WAIT -- requirements
Module: dmemory_wait

Interface
REQ-001 Parameter DW, default 48: data word width in bits.
REQ-002 Parameter AW, default 15: address width in bits.
REQ-003 Parameter DEPTH, default 32768: number of implemented words; legal range 1..2**AW.
REQ-004 Parameter WAIT, default 0: wait states added per access; legal range 0..15.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 i_addr  input  AW  word address of request.
REQ-008 i_read  input  1  read request, sampled when not busy.
REQ-009 i_write  input  1  write request, sampled when not busy.
REQ-010 i_data  input  DW  store data, sampled with i_write.
REQ-011 o_data  output  DW  load data; valid with o_done after a read, held until next read completes.
REQ-012 o_done  output  1  one-cycle completion pulse per accepted request.
REQ-013 o_busy  output  1  high while an access is in wait states; requests ignored.
REQ-014 o_err  output  1  one-cycle error pulse.

Function
REQ-015 States: IDLE, WAIT, DONE; o_busy SHALL equal (state == WAIT).
REQ-016 Request accepted in IDLE or DONE when exactly one of i_read/i_write is high; i_addr, i_data and op latched at that edge.
REQ-017 WAIT=0: accepted request performs its array access at the accepting edge, next state DONE; o_done high the following cycle (latency 1, one request per cycle sustained).
REQ-018 WAIT>0: accept loads wait counter with WAIT, next state WAIT; counter decrements each cycle; access performed at edge where counter is 1, next state DONE; o_done high WAIT+1 cycles after the request cycle.
REQ-019 DONE with no new accepted request returns to IDLE; DONE with accepted request follows REQ-017/018 (back-to-back).
REQ-020 Requests while o_busy is high SHALL be ignored: not queued, no o_err, no o_done.
REQ-021 i_read and i_write both high when not busy: no access, no o_done, o_err pulses next cycle, state goes IDLE.
REQ-022 Latched address >= DEPTH: write suppressed, read returns all-zero o_data, o_done and o_err pulse together.
REQ-023 Write completion leaves o_data unchanged.
REQ-024 Read of an address written by the immediately preceding completed write SHALL return the new data.
REQ-025 Wait counter width SHALL be $clog2(WAIT+1), minimum 1 bit.

Reset
REQ-026 reset_n low at a rising edge: state IDLE, counter 0, o_done 0, o_err 0, o_busy 0, o_data 0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset during WAIT abandons the pending access: no array write, no o_done.
REQ-029 Requests presented while reset_n is low are ignored.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum and default width constants (48-bit word, 15-bit address).
REQ-031 Sub-module dmem_array: single-port DW x DEPTH RAM, registered read, write enable, no reset; all control in dmemory_wait.

Verification
REQ-032 WAIT=0: write 0x123456789ABC to addr 5, read addr 5 next cycle -> o_done each following cycle, o_data=0x123456789ABC on read done.
REQ-033 WAIT=3: read at cycle 0 -> o_busy cycles 1-3, o_done and data at cycle 4; read issued at cycle 2 ignored.
REQ-034 i_read=i_write=1 at addr 7 -> o_err one cycle, o_done never, addr 7 unchanged on later read.
REQ-035 DEPTH=1000: write 0xFFFF to addr 1000 -> o_done+o_err; read addr 1000 -> o_data=0 with o_err.
REQ-036 WAIT=5: write 0xAAAA to addr 9, reset_n low at cycle 2 -> no o_done; read addr 9 returns prior contents.
REQ-037 Reset: all outputs 0 first cycle after reset; preloaded word at addr 0 survives reset.
